// File: rtl/bambu_mem_pkg.sv
// Shared definitions for the Bambu minimal-memory copy master.
// Contents:
//   - default per-channel widths (address, data, size) and the length operand width
//   - the copy FSM state type
//   - channel index constants: reads use channel RD_CH, writes use channel WR_CH
package bambu_mem_pkg;

    localparam int BAMBU_ADDR_W = 7;
    localparam int BAMBU_DATA_W = 8;
    localparam int BAMBU_SIZE_W = 4;
    localparam int BAMBU_LEN_W  = 8;

    localparam int RD_CH = 0;
    localparam int WR_CH = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } copy_state_t;

endpackage

// File: rtl/bambu_mem_fifo2.sv
// Two-entry byte buffer between the read and write engines of the copy master.
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-low reset
//   clear            empties the buffer (start of a new copy)
//   push, push_data  enqueue one entry
//   pop              dequeue the head entry; push and pop may coincide
//   head_next        the entry that will be at the head after this cycle
//   count            current occupancy (0..2)
//   count_next       occupancy after this cycle's push/pop
module bambu_mem_fifo2
    import bambu_mem_pkg::*;
#(
    parameter int DATA_W = BAMBU_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] head_next,
    output logic [1:0]        count,
    output logic [1:0]        count_next
);

    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;

    // data0 is always the head; data1 only holds the second entry when count==2.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= 2'd0;
            data0 <= '0;
            data1 <= '0;
        end else if (clear) begin
            count <= 2'd0;
        end else begin
            count <= count_next;
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) data0 <= push_data;
                    else               data1 <= push_data;
                end
                2'b01: data0 <= data1;
                2'b11: begin
                    if (count == 2'd1) begin
                        data0 <= push_data;
                    end else begin
                        data0 <= data1;
                        data1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + 2'd1;
        else if (pop && !push) count_next = count - 2'd1;
    end

    // Lets the write engine register the next write data in the same cycle
    // that a previous write completes, so writes can go back-to-back.
    always_comb begin
        head_next = data0;
        if (pop && push)               head_next = (count == 2'd1) ? push_data : data1;
        else if (pop)                  head_next = data1;
        else if (push && count == 2'd0) head_next = push_data;
    end

endmodule

// File: rtl/bambu_mem_copy_master.sv
// Copy master on the two-channel Bambu minimal memory interface.
// On start_port it copies len bytes from src_addr to dst_addr in ascending order.
// Channel 0 performs only reads, channel 1 only writes; a 2-entry buffer lets
// them overlap. A read reserves its buffer slot when issued, so the buffer
// cannot overflow.
// Ports:
//   clock, reset              rising-edge clock, asynchronous active-low reset
//   start_port                start pulse (ignored while busy)
//   src_addr, dst_addr, len   copy operands, sampled on an accepted start
//   done_port                 one-cycle completion pulse
//   busy                      high from the cycle after start through done_port
//   Mout_*                    registered request outputs, held until M_DataRdy
//   M_Rdata_ram, M_DataRdy    responder read data and per-channel completion
module bambu_mem_copy_master
    import bambu_mem_pkg::*;
#(
    parameter int ADDR_W = BAMBU_ADDR_W,
    parameter int DATA_W = BAMBU_DATA_W,
    parameter int SIZE_W = BAMBU_SIZE_W,
    parameter int LEN_W  = BAMBU_LEN_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start_port,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [LEN_W-1:0]    len,
    output logic                done_port,
    output logic                busy,
    output logic [1:0]          Mout_oe_ram,
    output logic [1:0]          Mout_we_ram,
    output logic [2*ADDR_W-1:0] Mout_addr_ram,
    output logic [2*DATA_W-1:0] Mout_Wdata_ram,
    output logic [2*SIZE_W-1:0] Mout_data_ram_size,
    input  logic [2*DATA_W-1:0] M_Rdata_ram,
    input  logic [1:0]          M_DataRdy
);

    copy_state_t       state;
    copy_state_t       next_state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  rd_idx;
    logic [LEN_W-1:0]  wr_idx;
    logic [LEN_W-1:0]  rd_idx_next;
    logic [LEN_W-1:0]  wr_idx_next;
    logic              rd_active;
    logic              wr_active;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_done;
    logic              wr_done;
    logic              rd_busy_next;
    logic              wr_busy_next;
    logic              rd_issue;
    logic              wr_issue;
    logic              fifo_clear;
    logic [DATA_W-1:0] head_next;
    logic [1:0]        count;
    logic [1:0]        count_next;
    logic              unused_rdata;

    // Completion strobes only count while the matching request is presented.
    assign rd_done      = rd_active & M_DataRdy[RD_CH];
    assign wr_done      = wr_active & M_DataRdy[WR_CH];
    assign rd_busy_next = rd_active & ~rd_done;
    assign wr_busy_next = wr_active & ~wr_done;
    assign rd_idx_next  = rd_idx + LEN_W'(rd_done);
    assign wr_idx_next  = wr_idx + LEN_W'(wr_done);
    assign fifo_clear   = (state == IDLE) && start_port;

    // With no read outstanding next cycle, the buffer occupancy alone decides
    // whether another slot can be reserved.
    assign rd_issue = (state == RUN) && !rd_busy_next &&
                      (rd_idx_next < len_q) && (count_next < 2'd2);
    assign wr_issue = (state == RUN) && !wr_busy_next && (count_next != 2'd0);

    bambu_mem_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .clear      (fifo_clear),
        .push       (rd_done),
        .pop        (wr_done),
        .push_data  (M_Rdata_ram[RD_CH*DATA_W +: DATA_W]),
        .head_next  (head_next),
        .count      (count),
        .count_next (count_next)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start_port) next_state = (len == '0) ? DONE : RUN;
            RUN:  if ((wr_idx_next == len_q) && !wr_busy_next) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request registers: the first read is launched straight from IDLE, then
    // each engine computes its next request from post-completion indices so
    // requests can follow each other without a bubble.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            rd_idx    <= '0;
            wr_idx    <= '0;
            rd_active <= 1'b0;
            wr_active <= 1'b0;
            rd_addr   <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_port) begin
                        src_q  <= src_addr;
                        dst_q  <= dst_addr;
                        len_q  <= len;
                        rd_idx <= '0;
                        wr_idx <= '0;
                        if (len != '0) begin
                            rd_active <= 1'b1;
                            rd_addr   <= src_addr;
                        end
                    end
                end
                RUN: begin
                    rd_idx <= rd_idx_next;
                    wr_idx <= wr_idx_next;
                    if (rd_issue) begin
                        rd_active <= 1'b1;
                        rd_addr   <= src_q + ADDR_W'(rd_idx_next);
                    end else if (rd_done) begin
                        rd_active <= 1'b0;
                    end
                    if (wr_issue) begin
                        wr_active <= 1'b1;
                        wr_addr   <= dst_q + ADDR_W'(wr_idx_next);
                        wr_data   <= head_next;
                    end else if (wr_done) begin
                        wr_active <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        Mout_oe_ram        = '0;
        Mout_we_ram        = '0;
        Mout_addr_ram      = '0;
        Mout_Wdata_ram     = '0;
        Mout_data_ram_size = '0;
        Mout_oe_ram[RD_CH] = rd_active;
        Mout_we_ram[WR_CH] = wr_active;
        Mout_addr_ram[RD_CH*ADDR_W +: ADDR_W]  = rd_addr;
        Mout_addr_ram[WR_CH*ADDR_W +: ADDR_W]  = wr_addr;
        Mout_Wdata_ram[WR_CH*DATA_W +: DATA_W] = wr_data;
        Mout_data_ram_size[RD_CH*SIZE_W +: SIZE_W] = rd_active ? SIZE_W'(DATA_W) : '0;
        Mout_data_ram_size[WR_CH*SIZE_W +: SIZE_W] = wr_active ? SIZE_W'(DATA_W) : '0;
    end

    assign busy         = (state != IDLE);
    assign done_port    = (state == DONE);
    assign unused_rdata = ^M_Rdata_ram[WR_CH*DATA_W +: DATA_W];

endmodule

// File: tb/tb_bambu_mem_copy_master.sv
// Self-checking bench for bambu_mem_copy_master.
// A behavioural memory responder serves both channels with random delays.
// A scoreboard holds the expected read/write addresses pushed at each start;
// a monitor pops and compares them on every completed bus transfer, and
// checks written bytes against the bytes the responder returned.
module tb_bambu_mem_copy_master;

    localparam int AW = 7;
    localparam int DW = 8;
    localparam int SW = 4;
    localparam int LW = 8;
    localparam int MEMSZ = 128;

    logic          clock;
    logic          reset;
    logic          start_port;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [LW-1:0] len;
    logic          done_port;
    logic          busy;
    logic [1:0]    oe;
    logic [1:0]    we;
    logic [2*AW-1:0] addr;
    logic [2*DW-1:0] wdata;
    logic [2*SW-1:0] size;
    logic [2*DW-1:0] rdata;
    logic [1:0]    rdy;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem  [MEMSZ];
    logic [7:0] snap [MEMSZ];
    int         exp_rd_q [$];
    int         exp_wr_q [$];
    logic [7:0] data_q   [$];
    int         rd_cnt;
    int         wr_cnt;
    bit         any_bus;
    int         rd_min, rd_max, wr_min, wr_max;
    bit         wr_stall;

    bambu_mem_copy_master dut (
        .clock              (clock),
        .reset              (reset),
        .start_port         (start_port),
        .src_addr           (src_addr),
        .dst_addr           (dst_addr),
        .len                (len),
        .done_port          (done_port),
        .busy               (busy),
        .Mout_oe_ram        (oe),
        .Mout_we_ram        (we),
        .Mout_addr_ram      (addr),
        .Mout_Wdata_ram     (wdata),
        .Mout_data_ram_size (size),
        .M_Rdata_ram        (rdata),
        .M_DataRdy          (rdy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Memory model: drives strobes at the falling edge so they are stable at the
    // next rising edge. A fresh delay is drawn whenever a new request starts.
    task automatic responder_loop();
        int rd_wait = 0;
        int wr_wait = 0;
        int rd_target = 1;
        int wr_target = 1;
        forever begin
            @(negedge clock);
            rdy = 2'b00;
            rdata = 16'($urandom);
            if (oe[0]) begin
                if (rd_wait == 0) rd_target = int'($urandom_range(rd_max, rd_min));
                rd_wait++;
                if (rd_wait >= rd_target) begin
                    rdy[0] = 1'b1;
                    rdata[DW-1:0] = mem[addr[AW-1:0]];
                    rd_wait = 0;
                end
            end else begin
                rd_wait = 0;
            end
            if (we[1]) begin
                if (wr_wait == 0) wr_target = int'($urandom_range(wr_max, wr_min));
                if (!wr_stall) begin
                    wr_wait++;
                    if (wr_wait >= wr_target) begin
                        rdy[1] = 1'b1;
                        mem[addr[2*AW-1:AW]] = wdata[2*DW-1:DW];
                        wr_wait = 0;
                    end
                end
            end else begin
                wr_wait = 0;
            end
        end
    endtask

    task automatic monitor_loop();
        int e;
        forever begin
            @(negedge clock);
            #2;
            if (reset) begin
                if (oe != 2'b00 || we != 2'b00) any_bus = 1'b1;
                if (busy) begin
                    check_output("unused_channel_enables", int'({oe[1], we[0]}), 0);
                    check_output("rd_size", int'(size[SW-1:0]), oe[0] ? DW : 0);
                    check_output("wr_size", int'(size[2*SW-1:SW]), we[1] ? DW : 0);
                    check_output("buffer_plus_outstanding_le_2",
                                 int'((rd_cnt - wr_cnt + int'(oe[0])) <= 2), 1);
                end
                if (oe[0] && rdy[0]) begin
                    if (exp_rd_q.size() == 0) begin
                        check_output("rd_unexpected_queue_size", exp_rd_q.size(), 1);
                    end else begin
                        e = exp_rd_q.pop_front();
                        check_output("rd_addr", int'(addr[AW-1:0]), e);
                    end
                    data_q.push_back(rdata[DW-1:0]);
                    rd_cnt++;
                end
                if (we[1] && rdy[1]) begin
                    if (exp_wr_q.size() == 0) begin
                        check_output("wr_unexpected_queue_size", exp_wr_q.size(), 1);
                    end else begin
                        e = exp_wr_q.pop_front();
                        check_output("wr_addr", int'(addr[2*AW-1:AW]), e);
                    end
                    if (data_q.size() == 0) begin
                        check_output("wr_data_without_read", data_q.size(), 1);
                    end else begin
                        check_output("wr_data", int'(wdata[2*DW-1:DW]), int'(data_q.pop_front()));
                    end
                    wr_cnt++;
                end
            end
        end
    endtask

    task automatic set_delays(input int rmin, input int rmax, input int wmin, input int wmax);
        rd_min = rmin; rd_max = rmax; wr_min = wmin; wr_max = wmax;
    endtask

    // Pushes the expected transfer sequence and pulses start. Returns #1 after
    // the edge that accepted the start.
    task automatic apply_stimulus(input int s, input int d, input int n);
        for (int i = 0; i < n; i++) begin
            exp_rd_q.push_back((s + i) % MEMSZ);
            exp_wr_q.push_back((d + i) % MEMSZ);
        end
        for (int i = 0; i < MEMSZ; i++) snap[i] = mem[i];
        rd_cnt = 0;
        wr_cnt = 0;
        any_bus = 1'b0;
        @(posedge clock);
        #1;
        src_addr = AW'(s);
        dst_addr = AW'(d);
        len = LW'(n);
        start_port = 1'b1;
        @(posedge clock);
        #1;
        start_port = 1'b0;
        src_addr = AW'($urandom);
        dst_addr = AW'($urandom);
        len = LW'($urandom);
        check_output("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_done(input string tag, input int limit);
        int cyc = 1;
        while (!done_port && cyc < 3000) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        if (!done_port) begin
            check_output({tag, "_done_timeout"}, 0, 1);
        end else begin
            check_output({tag, "_done_latency"}, (cyc <= limit) ? limit : cyc, limit);
            check_output({tag, "_busy_with_done"}, int'(busy), 1);
            @(posedge clock);
            #1;
            check_output({tag, "_done_single_pulse"}, int'(done_port), 0);
            check_output({tag, "_busy_after_done"}, int'(busy), 0);
            check_output({tag, "_reads_left"}, exp_rd_q.size(), 0);
            check_output({tag, "_writes_left"}, exp_wr_q.size(), 0);
        end
    endtask

    task automatic check_mem(input string tag, input int s, input int d, input int n);
        for (int i = 0; i < n; i++)
            check_output({tag, "_mem"}, int'(mem[(d + i) % MEMSZ]), int'(snap[(s + i) % MEMSZ]));
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_oe_we"}, int'({oe, we}), 0);
        check_output({tag, "_addr"}, int'(addr), 0);
        check_output({tag, "_wdata"}, int'(wdata), 0);
        check_output({tag, "_size"}, int'(size), 0);
        check_output({tag, "_done_busy"}, int'({done_port, busy}), 0);
    endtask

    logic [7:0] t1_exp [4];

    initial begin
        int n, s, d;
        reset = 1'b0;
        start_port = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len = '0;
        rdy = 2'b00;
        rdata = '0;
        wr_stall = 1'b0;
        rd_cnt = 0;
        wr_cnt = 0;
        any_bus = 1'b0;
        set_delays(1, 1, 1, 1);
        for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
        fork
            responder_loop();
            monitor_loop();
            begin
                #3000000;
                $display("[TB] FAIL watchdog: simulation time limit reached");
                $fatal(1, "[TB] watchdog");
            end
        join_none

        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b1;

        // Basic 4-byte copy with fixed delays.
        set_delays(2, 2, 1, 1);
        mem[16] = 8'h11; mem[17] = 8'h22; mem[18] = 8'h33; mem[19] = 8'h44;
        t1_exp[0] = 8'h11; t1_exp[1] = 8'h22; t1_exp[2] = 8'h33; t1_exp[3] = 8'h44;
        apply_stimulus(8'h10, 8'h40, 4);
        wait_done("basic4", 12);
        for (int i = 0; i < 4; i++) check_output("basic4_dst", int'(mem[8'h40 + i]), int'(t1_exp[i]));

        // Zero-length copy.
        set_delays(1, 3, 1, 3);
        apply_stimulus(8'h22, 8'h33, 0);
        wait_done("len0", 3);
        check_output("len0_no_bus_activity", int'(any_bus), 0);

        // Address wrap on both channels.
        apply_stimulus(8'h7E, 8'h7F, 3);
        wait_done("wrap", 40);

        // Write channel stalled: reads stop once the buffer is reserved.
        set_delays(1, 2, 1, 1);
        wr_stall = 1'b1;
        apply_stimulus(8'h20, 8'h50, 5);
        repeat (20) @(posedge clock);
        #1;
        check_output("stall_reads_done", rd_cnt, 2);
        check_output("stall_writes_done", wr_cnt, 0);
        check_output("stall_no_read_outstanding", int'(oe[0]), 0);
        check_output("stall_write_held", int'(we[1]), 1);
        wr_stall = 1'b0;
        wait_done("stall", 40);
        check_mem("stall", 8'h20, 8'h50, 5);

        // Start pulsed while busy must be ignored.
        set_delays(1, 3, 1, 3);
        apply_stimulus(8'h00, 8'h30, 10);
        repeat (4) @(posedge clock);
        #1;
        src_addr = 7'h60;
        dst_addr = 7'h08;
        len = 8'd7;
        start_port = 1'b1;
        @(posedge clock);
        #1;
        start_port = 1'b0;
        wait_done("midstart", 200);
        check_mem("midstart", 8'h00, 8'h30, 10);

        // Reset during RUN, then a fresh copy.
        apply_stimulus(8'h05, 8'h45, 12);
        repeat (6) @(posedge clock);
        #1;
        check_output("midreset_busy_before", int'(busy), 1);
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_rd_q.delete();
        exp_wr_q.delete();
        data_q.delete();
        repeat (2) @(negedge clock);
        check_all_zero("midreset_held");
        reset = 1'b1;
        apply_stimulus(8'h0A, 8'h5A, 6);
        wait_done("after_reset", 80);
        check_mem("after_reset", 8'h0A, 8'h5A, 6);

        // Randomised disjoint copies.
        for (int t = 0; t < 6; t++) begin
            n = int'($urandom_range(20, 1));
            s = int'($urandom_range(127, 0));
            d = (s + n + int'($urandom_range(MEMSZ - 2 * n, 0))) % MEMSZ;
            set_delays(1, int'($urandom_range(3, 1)), 1, int'($urandom_range(3, 1)));
            apply_stimulus(s, d, n);
            wait_done("random", n * 8 + 10);
            check_mem("random", s, d, n);
        end

        // Maximum length, in-place copy.
        set_delays(1, 1, 1, 1);
        apply_stimulus(0, 0, 255);
        wait_done("maxlen", 255 * 4 + 10);
        check_mem("maxlen", 0, 0, 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bambu_mem_copy_master.md
Name: bambu_mem_copy_master

Overview:
- Synthesizable initiator for the two-channel Bambu minimal memory interface. It drives Mout_oe_ram/Mout_we_ram/Mout_addr_ram/Mout_Wdata_ram/Mout_data_ram_size and consumes M_Rdata_ram/M_DataRdy.
- On start_port it copies len bytes from src_addr to dst_addr, ascending.
- Channel 0 carries only reads and channel 1 carries only writes; the two channels overlap through a 2-entry buffer.
- Used to preload and copy testbench/accelerator memories without the simulation-only loader.

Parameters:
- ADDR_W, 7, per-channel byte-address width.
- DATA_W, 8, per-channel data width; one byte per access.
- SIZE_W, 4, per-channel data_ram_size width.
- LEN_W, 8, width of the len operand.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_port  in  1  one-cycle start pulse; ignored while busy.
- src_addr  in  ADDR_W  source base byte address; sampled on start.
- dst_addr  in  ADDR_W  destination base byte address; sampled on start.
- len  in  LEN_W  byte count; sampled on start.
- done_port  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after an accepted start through the done_port cycle.
- Mout_oe_ram  out  2  per-channel read enable; [0] used, [1] tied 0.
- Mout_we_ram  out  2  per-channel write enable; [1] used, [0] tied 0.
- Mout_addr_ram  out  2*ADDR_W  channel c address at [c*ADDR_W +: ADDR_W].
- Mout_Wdata_ram  out  2*DATA_W  channel c write data at [c*DATA_W +: DATA_W].
- Mout_data_ram_size  out  2*SIZE_W  per-channel access size in bits.
- M_Rdata_ram  in  2*DATA_W  read data; channel 0 slice is valid in the cycle M_DataRdy[0]=1.
- M_DataRdy  in  2  per-channel completion strobe from the responder.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; buffer empty; indices 0.
- All bus outputs are registered.
- Protocol: a request's oe/we, addr, Wdata and size are held stable until the cycle in which the matching M_DataRdy bit is 1.
  - The next request on the same channel may be presented in the following cycle (back-to-back allowed).
  - Size equals DATA_W on an active channel and 0 on an idle channel.
  - oe and we are never both high on one channel.
- FSM states:
  - IDLE: start_port=1 latches src/dst/len, clears rd_idx, wr_idx and the buffer, then goes to RUN; if len=0 goes to DONE instead.
  - RUN: read engine and write engine run concurrently (rules below). Go to DONE when wr_idx==len and no write is outstanding.
  - DONE: done_port=1 for exactly one cycle, busy still 1, then IDLE. start_port in DONE is ignored.
- Read engine:
  - Issue a read at address src+rd_idx (mod 2^ADDR_W) when rd_idx<len and (buffer occupancy + outstanding reads) < 2. At most one read is outstanding.
  - On M_DataRdy[0]: push M_Rdata_ram[DATA_W-1:0] into the buffer, rd_idx++.
- Write engine:
  - Issue a write of the buffer head to dst+wr_idx when the buffer is non-empty and no write is outstanding.
  - On M_DataRdy[1]: pop the buffer, wr_idx++.
- Simultaneous push and pop in one cycle is legal; occupancy stays unchanged.
- The buffer can never overflow, because a read's slot is reserved at issue time.
- M_DataRdy bits arriving while the corresponding channel is idle are ignored.
- Address wrap: base+index wraps modulo 2^ADDR_W. Overlapping src/dst is a plain ascending copy; no overlap handling.
- len=2^LEN_W-1 is the maximum transfer. Indices are LEN_W bits wide and cannot overflow, because they stop at len.
- Reset asserted mid-transfer: all outputs drop to 0 asynchronously, no done_port is produced, and the outstanding request is abandoned.

Decomposition:
- Shared package bambu_mem_pkg: ADDR_W/DATA_W/SIZE_W defaults, the FSM state enum (IDLE, RUN, DONE), and channel index constants (RD_CH=0, WR_CH=1).
- One natural sub-module: bambu_mem_fifo2, a 2-entry DATA_W FIFO with push/pop/occupancy and legal simultaneous push+pop.

Test Plan:
- Copy 4 bytes with the responder at read delay 2 and write delay 1; src=0x10 holds 11 22 33 44, dst=0x40 -> dst holds 11 22 33 44; done_port is a single pulse ≤12 cycles after start; no we/oe overlap on any channel.
- len=0 -> done_port pulses within 3 cycles of start; Mout_oe_ram and Mout_we_ram stay 0 throughout.
- Wrap case: src=0x7E, dst=0x7F, len=3 -> reads issued to 7E,7F,00 and writes to 7F,00,01.
- Write channel stalled (M_DataRdy[1] held 0 for 20 cycles), len=5 -> at most 2 reads complete plus none outstanding beyond the buffer; the copy resumes with correct data once writes are released.
- start_port pulsed mid-transfer with different operands -> ignored; the original copy completes unchanged.
- reset pulled low during RUN -> all outputs 0 immediately; after release, a new start copies correctly.
